// File: rtl/word_set_pkg.sv
// Shared types and sizing helpers for the word set collector.
package word_set_pkg;

    typedef enum logic {
        FILL = 1'b0,
        WAIT = 1'b1
    } setState_e;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_NCH   = 2;

    // Slot index width; never narrower than one bit.
    function automatic int idxWidth(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/word_set_slot.sv
// One WIDTH-bit storage slot: load enable plus synchronous clear.
module word_set_slot #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] qReg;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            qReg <= '0;
        end else if (load) begin
            qReg <= d;
        end
    end

    assign q = qReg;

endmodule

// File: rtl/word_set_bank.sv
// Serial-to-parallel word set collector with separate fill and output banks.
// Optional per-channel parity output when WORD_SET_PARITY_EN is defined.
module word_set_bank
    import word_set_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NCH   = DEFAULT_NCH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   bitEnable,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_word,
    output logic                   out_valid,
    input  logic                   out_ack,
    output logic [NCH*WIDTH-1:0]   out_words
`ifdef WORD_SET_PARITY_EN
    ,
    output logic [NCH-1:0]         out_parity
`endif
);

    localparam int IW = idxWidth(NCH);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

    setState_e      stateReg, stateNext;
    logic [IW-1:0]  idxReg, idxNext;
    logic           outValidReg, outValidNext;

    logic           clrEff;
    logic           accept;
    logic           ackEff;
    logic           isLast;
    logic           outFree;
    logic           outLoad;

    logic [WIDTH-1:0] fillQ [NCH];
    logic [WIDTH-1:0] outQ  [NCH];
    logic [WIDTH-1:0] outD  [NCH];
    logic [NCH-1:0]   fillLoad;

    always_comb begin
        clrEff       = clear & bitEnable;
        in_ready     = bitEnable & (stateReg == FILL);
        accept       = in_valid & in_ready;
        ackEff       = out_ack & outValidReg & bitEnable;
        isLast       = (idxReg == LAST_IDX);
        outFree      = ~outValidReg | ackEff;
        stateNext    = stateReg;
        idxNext      = idxReg;
        outValidNext = outValidReg;
        outLoad      = 1'b0;
        if (bitEnable) begin
            case (stateReg)
                FILL: begin
                    if (accept && !isLast) begin
                        idxNext = idxReg + IW'(1);
                    end
                    if (accept && isLast) begin
                        if (outFree) begin
                            outLoad      = 1'b1;
                            outValidNext = 1'b1;
                            idxNext      = '0;
                        end else begin
                            stateNext = WAIT;
                        end
                    end else if (ackEff) begin
                        outValidNext = 1'b0;
                    end
                end
                WAIT: begin
                    // Held set moves out as the consumer frees the bank; valid stays high.
                    if (ackEff) begin
                        outLoad   = 1'b1;
                        idxNext   = '0;
                        stateNext = FILL;
                    end
                end
                default: stateNext = FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clrEff) begin
            stateReg    <= FILL;
            idxReg      <= '0;
            outValidReg <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            idxReg      <= idxNext;
            outValidReg <= outValidNext;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_slot
            assign fillLoad[gi] = accept & (idxReg == IW'(gi));

            // The last channel bypasses the fill bank when a set completes in FILL.
            if (gi == NCH - 1) begin : g_last
                assign outD[gi] = (stateReg == FILL) ? in_word : fillQ[gi];
            end else begin : g_mid
                assign outD[gi] = fillQ[gi];
            end

            word_set_slot #(.WIDTH(WIDTH)) uFill (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (clrEff),
                .load  (fillLoad[gi]),
                .d     (in_word),
                .q     (fillQ[gi])
            );

            word_set_slot #(.WIDTH(WIDTH)) uOut (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (clrEff),
                .load  (outLoad),
                .d     (outD[gi]),
                .q     (outQ[gi])
            );

            assign out_words[gi*WIDTH +: WIDTH] = outQ[gi] & {WIDTH{bitEnable}};
        end
    endgenerate

    assign out_valid = outValidReg & bitEnable;

`ifdef WORD_SET_PARITY_EN
    logic [NCH-1:0] parityReg;

    always_ff @(posedge clk) begin
        if (!rst_n || clrEff) begin
            parityReg <= '0;
        end else if (outLoad) begin
            for (int k = 0; k < NCH; k++) begin
                parityReg[k] <= ^outD[k];
            end
        end
    end

    assign out_parity = parityReg & {NCH{bitEnable}};
`endif

endmodule

// File: tb/tb_word_set_bank.sv
// Self-checking bench for word_set_bank: directed scenarios plus randomized traffic vs. a queue model.
module tb_word_set_bank;

    localparam int WIDTH = 4;
    localparam int NCH   = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 bitEnable;
    logic                 clear;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_word;
    logic                 out_valid;
    logic                 out_ack;
    logic [NCH*WIDTH-1:0] out_words;
`ifdef WORD_SET_PARITY_EN
    logic [NCH-1:0]       out_parity;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    word_set_bank #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bitEnable (bitEnable),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .out_words (out_words)
`ifdef WORD_SET_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    // Reference: words gathered so far, the presented set, and whether a full set is stuck waiting.
    logic [WIDTH-1:0]     partial[$];
    logic [NCH*WIDTH-1:0] mOut;
    bit                   mValid;
    bit                   mPending;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NCH*WIDTH-1:0] packSet();
        logic [NCH*WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < NCH; k++) r[k*WIDTH +: WIDTH] = partial[k];
        return r;
    endfunction

    task automatic modelReset();
        partial.delete();
        mOut     = '0;
        mValid   = 1'b0;
        mPending = 1'b0;
    endtask

    task automatic modelEdge();
        bit ackEff;
        bit acc;
        if (!rst_n) begin
            modelReset();
        end else if (bitEnable) begin
            if (clear) begin
                modelReset();
            end else begin
                ackEff = out_ack && mValid;
                acc    = in_valid && !mPending;
                if (ackEff) $display("set taken: %h", mOut);
                if (mPending) begin
                    if (ackEff) begin
                        mOut     = packSet();
                        mPending = 1'b0;
                        partial.delete();
                    end
                end else begin
                    if (acc) partial.push_back(in_word);
                    if (acc && partial.size() == NCH) begin
                        if (!mValid || ackEff) begin
                            mOut   = packSet();
                            mValid = 1'b1;
                            partial.delete();
                        end else begin
                            mPending = 1'b1;
                        end
                    end else if (ackEff) begin
                        mValid = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic checkOutputs(input string tag);
        checkVal({tag, ":ready"}, in_ready, bitEnable && !mPending);
        checkVal({tag, ":valid"}, out_valid, bitEnable && mValid);
        checkVal({tag, ":words"}, out_words, bitEnable ? mOut : '0);
`ifdef WORD_SET_PARITY_EN
        begin
            logic [NCH-1:0] p;
            for (int k = 0; k < NCH; k++) p[k] = ^mOut[k*WIDTH +: WIDTH];
            checkVal({tag, ":parity"}, out_parity, bitEnable ? p : '0);
        end
`endif
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        modelEdge();
        #1;
        checkOutputs(tag);
    endtask

    initial begin
        rst_n = 1'b0; bitEnable = 1'b1; clear = 1'b0;
        in_valid = 1'b0; in_word = '0; out_ack = 1'b0;
        step("rst");
        step("rst");
        rst_n = 1'b1;
        checkVal("rst_valid", out_valid, 1'b0);
        checkVal("rst_ready", in_ready, 1'b1);

        // Two words with ack held: set appears right after the second accept.
        out_ack = 1'b1; in_valid = 1'b1;
        in_word = 4'd14; step("p1");
        in_word = 4'd15; step("p1");
        in_valid = 1'b0; out_ack = 1'b0;
        checkVal("p1_valid", out_valid, 1'b1);
        checkVal("p1_words", out_words, 8'hFE);

        bitEnable = 1'b0; step("en0");
        checkVal("en0_words", out_words, 8'h00);
        checkVal("en0_valid", out_valid, 1'b0);
        checkVal("en0_ready", in_ready, 1'b0);
        bitEnable = 1'b1; #1;
        checkVal("en1_words", out_words, 8'hFE);
        checkVal("en1_valid", out_valid, 1'b1);

        // Consumer stalls: second set parks in WAIT.
        clear = 1'b1; step("clr"); clear = 1'b0;
        in_valid = 1'b1;
        in_word = 4'd8;  step("w");
        in_word = 4'd9;  step("w");
        checkVal("w_first", out_words, 8'h98);
        in_word = 4'd10; step("w");
        in_word = 4'd11; step("w");
        checkVal("w_ready", in_ready, 1'b0);
        in_word = 4'd12; step("w_hold");
        checkVal("w_hold", out_words, 8'h98);
        in_valid = 1'b0; out_ack = 1'b1; step("w_ack"); out_ack = 1'b0;
        checkVal("w_second", out_words, 8'hBA);
        checkVal("w_ready1", in_ready, 1'b1);
        checkVal("w_valid", out_valid, 1'b1);

        // Streaming with ack every cycle.
        clear = 1'b1; step("clr"); clear = 1'b0;
        out_ack = 1'b1; in_valid = 1'b1;
        for (int w = 1; w <= 8; w++) begin
            in_word = WIDTH'(w);
            step("str");
            checkVal("str_ready", in_ready, 1'b1);
            if (w % 2 == 0) checkVal("str_set", out_words, {4'(w), 4'(w - 1)});
        end
        in_valid = 1'b0; out_ack = 1'b0;

        // Partial set discarded by clear, then by reset.
        for (int r = 0; r < 2; r++) begin
            in_valid = 1'b1; in_word = 4'd6; step("flush");
            in_valid = 1'b0;
            if (r == 0) clear = 1'b1; else rst_n = 1'b0;
            step("flush");
            clear = 1'b0; rst_n = 1'b1;
            in_valid = 1'b1;
            in_word = 4'd3; step("flush");
            in_word = 4'd5; step("flush");
            in_valid = 1'b0;
            checkVal(r == 0 ? "clear_set" : "reset_set", out_words, 8'h53);
        end

`ifdef WORD_SET_PARITY_EN
        clear = 1'b1; step("clr"); clear = 1'b0;
        in_valid = 1'b1;
        in_word = 4'd7; step("par");
        in_word = 4'd3; step("par");
        in_valid = 1'b0;
        checkVal("par_bits", out_parity, 2'b01);
`endif

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            bitEnable = ($urandom_range(0, 9) != 0);
            clear     = ($urandom_range(0, 39) == 0);
            rst_n     = ($urandom_range(0, 99) != 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ack   = ($urandom_range(0, 1) == 1);
            in_word   = WIDTH'($urandom);
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
